// File: rtl/mac_chain_ctrl.sv
// mac_chain_ctrl: CBC-style sequencer for the combinational macgen datapath.
// Optional length-padding cycle enabled by defining MAC_LEN_PAD_EN.
module mac_chain_ctrl #(
  parameter int N     = 256,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_len,
  input  logic [N-1:0]     key,
  input  logic             abort,
  input  logic             chunk_valid,
  input  logic [N-1:0]     chunk_data,
  output logic             chunk_ready,
  output logic             mg_enable,
  output logic [N-1:0]     mg_key,
  output logic [N-1:0]     mg_data,
  input  logic [N-1:0]     mg_mac,
  output logic [N-1:0]     mac_out,
  output logic             mac_valid,
  input  logic             mac_ack,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd3;
`ifdef MAC_LEN_PAD_EN
  localparam logic [1:0] S_PAD  = 2'd2;
  // Every message, including an empty one, ends with the length block.
  localparam logic [1:0] S_TAIL = S_PAD;
`else
  localparam logic [1:0] S_TAIL = S_DONE;
`endif

  logic [1:0]       state, state_nxt;
  logic [N-1:0]     acc, acc_nxt;
  logic [N-1:0]     key_q, key_nxt;
  logic [LEN_W-1:0] len_q, len_nxt;
  logic [LEN_W-1:0] cnt, cnt_nxt;
  logic             hs;
  logic             last_chunk;

  assign hs         = (state == S_RUN) && chunk_valid;
  // len_q is never 0 in RUN, so the subtraction cannot wrap.
  assign last_chunk = (cnt == len_q - LEN_W'(1));

  always_comb begin
    // NOTE: every variable gets a default before the case so no latch is inferred.
    state_nxt = state;
    acc_nxt   = acc;
    key_nxt   = key_q;
    len_nxt   = len_q;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          key_nxt   = key;
          len_nxt   = msg_len;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = (msg_len == '0) ? S_TAIL : S_RUN;
        end
      end
      S_RUN: begin
        if (hs) begin
          acc_nxt = mg_mac;
          cnt_nxt = cnt + LEN_W'(1);
          if (last_chunk) state_nxt = S_TAIL;
        end
      end
`ifdef MAC_LEN_PAD_EN
      S_PAD: begin
        acc_nxt   = mg_mac;
        state_nxt = S_DONE;
      end
`endif
      S_DONE: begin
        if (mac_ack) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Abort overrides a same-cycle handshake or acknowledge.
    if (abort && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
      acc_nxt   = '0;
      cnt_nxt   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      acc   <= '0;
      key_q <= '0;
      len_q <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      key_q <= key_nxt;
      len_q <= len_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    chunk_ready = (state == S_RUN);
    busy        = (state != S_IDLE);
    mac_valid   = (state == S_DONE);
    mac_out     = (state == S_DONE) ? acc : '0;
    mg_key      = key_q;
    mg_enable   = 1'b0;
    mg_data     = '0;
    if (state == S_RUN) begin
      mg_enable = chunk_valid;
      mg_data   = chunk_data ^ acc;
    end
`ifdef MAC_LEN_PAD_EN
    if (state == S_PAD) begin
      mg_enable = 1'b1;
      mg_data   = {{(N-LEN_W){1'b0}}, len_q} ^ acc;
    end
`endif
  end

endmodule
